// File: rtl/sm_debug_dump.sv
// Execution monitor and register-file dumper for sm_top's debug side.
// Counts EBREAKs, tracks the longest pc dwell, halts on WFI and streams a pc/err/regfile frame.
module sm_debug_dump #(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc,
   input  logic [31:0]       instr,
   output logic [ADDR_W-1:0] regAddr,
   input  logic [31:0]       regData,
   input  logic              start,
   output logic              out_valid,
   output logic [31:0]       out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              cpu_halt,
   output logic [15:0]       err_count,
   output logic [CNT_W-1:0]  stall_max,
   output logic              busy
);

   localparam logic [31:0] EBREAK = 32'h00100073;
   localparam logic [31:0] WFI    = 32'h10500073;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

   typedef enum logic [2:0] {IDLE, HDR_PC, HDR_ERR, ADDR, DATA} state_t;

   state_t            state;
   logic [31:0]       pcPrev;
   logic [31:0]       snapPc;
   logic [15:0]       snapErr;
   logic              firstEvt;
   logic [CNT_W-1:0]  dwell;
   logic [ADDR_W-1:0] idx;
   logic              evt;
   logic              isEbreak;
   logic              isWfi;
   logic              trig;

   always_comb begin
      evt      = firstEvt || (pc != pcPrev);
      isEbreak = evt && (instr == EBREAK);
      isWfi    = evt && (instr == WFI);
      trig     = (state == IDLE) && (start || isWfi);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pcPrev    <= '0;
         snapPc    <= '0;
         snapErr   <= '0;
         firstEvt  <= 1'b1;
         dwell     <= '0;
         idx       <= '0;
         regAddr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         cpu_halt  <= 1'b0;
         err_count <= '0;
         stall_max <= '0;
         busy      <= 1'b0;
      end else begin
         firstEvt <= 1'b0;
         pcPrev   <= pc;

         if (evt)
            dwell <= CNT_W'(1);
         else if (dwell != '1)
            dwell <= dwell + CNT_W'(1);
         if (dwell > stall_max)
            stall_max <= dwell;

         if (isEbreak && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
         if (isWfi)
            cpu_halt <= 1'b1;

         case (state)
            IDLE: begin
               // snapshot err_count before any same-cycle EBREAK increment lands
               if (trig) begin
                  state   <= HDR_PC;
                  snapPc  <= pc;
                  snapErr <= err_count;
                  idx     <= '0;
               end
            end
            HDR_PC: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= snapPc;
                  busy      <= 1'b1;
               end else if (out_ready) begin
                  out_data <= {16'b0, snapErr};
                  state    <= HDR_ERR;
               end
            end
            HDR_ERR: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  regAddr   <= idx;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               out_data  <= regData;
               out_valid <= 1'b1;
               out_last  <= (idx == LAST_IDX);
               state     <= DATA;
            end
            DATA: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     idx     <= idx + ADDR_W'(1);
                     regAddr <= idx + ADDR_W'(1);
                     state   <= ADDR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
